decodificador: RTL and testbench
================================

DECODIFICADOR -- requirements
Module: decodificador

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 Code  input  4  Excess-3 coded digit; must be stable from the Ready rising edge until Busy returns to 0.
REQ-005 Ready  input  1  asynchronous request strobe (button/level); one decode per 0->1 transition.
REQ-006 Digit  output  4  decoded BCD value (0-9), held between decodes.
REQ-007 Display  output  7  seven-segment pattern {a,b,c,d,e,f,g} = Display[6:0], active-high, held between decodes.
REQ-008 Valid  output  1  one-cycle pulse when a legal code has been decoded.
REQ-009 Error  output  1  level; 1 when the most recent decode saw an illegal code.
REQ-010 Busy  output  1  1 whenever the FSM is not in IDLE.
REQ-011 Count  output  4  number of legal decodes since reset, modulo 16.

Function
REQ-012 Ready SHALL pass through a 3-flop chain s1->s2->s3; rise = s2 & ~s3.
REQ-013 FSM states SHALL be IDLE, CHECK and SHOW, with no other reachable state.
REQ-014 IDLE->CHECK SHALL occur on the edge where rise=1, registering Code into an internal code register on that same edge.
REQ-015 CHECK->SHOW SHALL occur on the next edge, updating Digit, Display, Error, Count and Valid on that same edge.
REQ-016 SHOW->IDLE SHALL occur unconditionally on the next edge, and Valid SHALL return to 0 on that edge.
REQ-017 Latency: if edge E0 is the first edge sampling Ready=1, outputs SHALL update at E3 and Valid SHALL be high for the single cycle between E3 and E4.
REQ-018 A legal code (0011..1100) SHALL produce Digit = code - 3 (4-bit subtraction, no wrap possible), Error=0, Valid pulse, and Count+1.
REQ-019 Count SHALL wrap from 15 to 0.
REQ-020 An illegal code (0000-0010, 1101-1111) SHALL produce Error=1 and Display=1001111 ("E"), SHALL leave Digit and Count unchanged, and SHALL NOT pulse Valid.
REQ-021 Display patterns 0-9 SHALL be, in order: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
REQ-022 A rise occurring while Busy=1 SHALL be discarded, with no queuing and no effect on the current decode.
REQ-023 Ready held high indefinitely SHALL produce exactly one decode; a new decode requires Ready=0 for at least 2 clocks, then a return to 1.
REQ-024 Ready pulses shorter than one clock period SHALL NOT be required to be detected.
REQ-025 Code changes during CHECK or SHOW SHALL NOT affect the result, because the registered copy is used.

Reset
REQ-026 While Reset=0: FSM=IDLE, Digit=0000, Display=0000000 (blank), Valid=0, Error=0, Busy=0, Count=0000, code register=0000.
REQ-027 The s1, s2 and s3 flops SHALL reset to 1, so that Ready held high across reset release causes no decode.
REQ-028 Reset asserted in CHECK or SHOW SHALL abort the decode, force REQ-026 values asynchronously, and emit no Valid pulse.
REQ-029 After release, the first decode SHALL require a fresh Ready 0->1 transition.

Verification
REQ-030 Reset, then Code=0011 with Ready low->high -> at E3: Digit=0000, Display=1111110, Valid=1 for one cycle, Count=1, Error=0, Busy=1 from E2 to E4.
REQ-031 Code=1100 with a Ready rise -> Digit=1001, Display=1111011; then Code=1111 with a Ready rise -> Error=1, Display=1001111, Digit stays 1001, Count unchanged, Valid stays 0.
REQ-032 Ready held high for 20 cycles with Code=0111 -> exactly one Valid pulse, Digit=0100, Display=0110011, Count incremented by 1.
REQ-033 Second Ready rise issued 1 cycle after the FSM enters CHECK -> ignored, one Valid only, Busy=0 at E4.
REQ-034 16 legal decodes after reset -> Count=0000 after the 16th; the 17th -> Count=0001.
REQ-035 Reset driven low while in CHECK -> all outputs at REQ-026 values without waiting for a clock edge, no Valid; Ready held high across release -> no decode.

Source files
------------

// File: rtl/decodificador.sv
// decodificador: Excess-3 to BCD / seven-segment decoder driven by an
// asynchronous request strobe.
//
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   asynchronous, active-low reset
//   Code    in   [3:0] Excess-3 digit, sampled when a Ready rise is accepted
//   Ready   in   asynchronous request strobe, one decode per 0->1 transition
//   Digit   out  [3:0] decoded BCD value, held between decodes
//   Display out  [6:0] segments {a,b,c,d,e,f,g}, active-high, held
//   Valid   out  one-cycle pulse after a legal decode
//   Error   out  level, set when the latest decode saw an illegal code
//   Busy    out  high whenever the FSM is not idle
//   Count   out  [3:0] legal decodes since reset, modulo 16
module decodificador (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Code,
    input  logic       Ready,
    output logic [3:0] Digit,
    output logic [6:0] Display,
    output logic       Valid,
    output logic       Error,
    output logic       Busy,
    output logic [3:0] Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        SHOW  = 2'b10
    } state_t;

    state_t     state, state_next;
    logic       s1, s2, s3;
    logic       rise;
    logic       load_code;
    logic       commit;
    logic [3:0] code_q;
    logic       legal;
    logic [3:0] digit_next;
    logic [6:0] seg_next;

    // Synchroniser plus edge detector. Flops reset to 1 so that Ready
    // already high when reset releases does not look like a new request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= Ready;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rises seen outside IDLE are dropped, not queued.
    always_comb begin
        state_next = state;
        load_code  = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = CHECK;
                    load_code  = 1'b1;
                end
            end
            CHECK: begin
                state_next = SHOW;
                commit     = 1'b1;
            end
            SHOW: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Busy = (state != IDLE);

    always_comb begin
        legal      = (code_q >= 4'd3) && (code_q <= 4'd12);
        digit_next = code_q - 4'd3;
        case (digit_next)
            4'd0:    seg_next = 7'b1111110;
            4'd1:    seg_next = 7'b0110000;
            4'd2:    seg_next = 7'b1101101;
            4'd3:    seg_next = 7'b1111001;
            4'd4:    seg_next = 7'b0110011;
            4'd5:    seg_next = 7'b1011011;
            4'd6:    seg_next = 7'b1011111;
            4'd7:    seg_next = 7'b1110000;
            4'd8:    seg_next = 7'b1111111;
            4'd9:    seg_next = 7'b1111011;
            default: seg_next = 7'b1001111;
        endcase
    end

    // Valid defaults low every cycle, so it is high only for the cycle
    // spent in SHOW after a legal decode.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            code_q  <= '0;
            Digit   <= '0;
            Display <= '0;
            Valid   <= 1'b0;
            Error   <= 1'b0;
            Count   <= '0;
        end else begin
            Valid <= 1'b0;
            if (load_code) begin
                code_q <= Code;
            end
            if (commit) begin
                if (legal) begin
                    Digit   <= digit_next;
                    Display <= seg_next;
                    Error   <= 1'b0;
                    Count   <= Count + 4'd1;
                    Valid   <= 1'b1;
                end else begin
                    Error   <= 1'b1;
                    Display <= 7'b1001111;
                end
            end
        end
    end

endmodule

// File: tb/tb_decodificador.sv
// tb_decodificador: directed self-checking bench for decodificador.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_decodificador;

    logic       Clock;
    logic       Reset;
    logic [3:0] Code;
    logic       Ready;
    logic [3:0] Digit;
    logic [6:0] Display;
    logic       Valid;
    logic       Error;
    logic       Busy;
    logic [3:0] Count;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] SEG [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] SEG_E = 7'b1001111;

    decodificador dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Code    (Code),
        .Ready   (Ready),
        .Digit   (Digit),
        .Display (Display),
        .Valid   (Valid),
        .Error   (Error),
        .Busy    (Busy),
        .Count   (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full request: Ready rises at a falling edge, so the next rising
    // edge is E0. Falling edge 3 lies in CHECK, 4 in SHOW, 5 back in IDLE.
    task automatic decode(input string tag, input logic [3:0] c, input logic exp_valid,
                          input logic [3:0] exp_digit, input logic [6:0] exp_disp,
                          input logic exp_err, input logic [3:0] exp_cnt);
        Code  = c;
        Ready = 1'b1;
        repeat (3) @(negedge Clock);
        check({tag, "_busy_check"}, Busy, 1'b1);
        check({tag, "_valid_check"}, Valid, 1'b0);
        Code = ~c;
        @(negedge Clock);
        check({tag, "_valid"}, Valid, exp_valid);
        check({tag, "_digit"}, Digit, exp_digit);
        check({tag, "_display"}, Display, exp_disp);
        check({tag, "_error"}, Error, exp_err);
        check({tag, "_count"}, Count, exp_cnt);
        check({tag, "_busy_show"}, Busy, 1'b1);
        @(negedge Clock);
        check({tag, "_valid_end"}, Valid, 1'b0);
        check({tag, "_busy_end"}, Busy, 1'b0);
        Ready = 1'b0;
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        int vcount;
        int bcount;
        Reset = 1'b0;
        Ready = 1'b0;
        Code  = 4'b0000;

        // Reset values
        repeat (2) @(negedge Clock);
        check("rst_digit", Digit, 4'b0000);
        check("rst_display", Display, 7'b0000000);
        check("rst_valid", Valid, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_count", Count, 4'b0000);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);

        // Basic legal and illegal decodes
        decode("d0011", 4'b0011, 1'b1, 4'd0, SEG[0], 1'b0, 4'd1);
        decode("d1100", 4'b1100, 1'b1, 4'd9, SEG[9], 1'b0, 4'd2);
        decode("d1111", 4'b1111, 1'b0, 4'd9, SEG_E, 1'b1, 4'd2);

        // Ready held high for 20 cycles gives a single decode
        Code   = 4'b0111;
        Ready  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (Valid) vcount++;
        end
        check("hold_pulses", vcount, 1);
        check("hold_digit", Digit, 4'd4);
        check("hold_display", Display, SEG[4]);
        check("hold_error", Error, 1'b0);
        check("hold_count", Count, 4'd3);
        Ready = 1'b0;
        repeat (3) @(negedge Clock);

        // Second rise arriving while busy is dropped
        Code  = 4'b1000;
        Ready = 1'b1;
        @(negedge Clock);
        Ready = 1'b0;
        @(negedge Clock);
        Ready  = 1'b1;
        vcount = 0;
        @(negedge Clock);
        check("busy_rise_in_check", Busy, 1'b1);
        @(negedge Clock);
        if (Valid) vcount++;
        @(negedge Clock);
        check("busy_rise_idle_e4", Busy, 1'b0);
        bcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (Valid) vcount++;
            if (Busy) bcount++;
        end
        check("busy_rise_pulses", vcount, 1);
        check("busy_rise_no_restart", bcount, 0);
        check("busy_rise_digit", Digit, 4'd5);
        check("busy_rise_count", Count, 4'd4);
        Ready = 1'b0;
        repeat (3) @(negedge Clock);

        // Reset during CHECK aborts asynchronously
        Code  = 4'b0101;
        Ready = 1'b1;
        repeat (3) @(negedge Clock);
        check("abort_busy_before", Busy, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("abort_digit", Digit, 4'b0000);
        check("abort_display", Display, 7'b0000000);
        check("abort_valid", Valid, 1'b0);
        check("abort_error", Error, 1'b0);
        check("abort_busy", Busy, 1'b0);
        check("abort_count", Count, 4'b0000);
        @(negedge Clock);
        Reset  = 1'b1;
        vcount = 0;
        bcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Valid) vcount++;
            if (Busy) bcount++;
        end
        check("abort_release_valid", vcount, 0);
        check("abort_release_busy", bcount, 0);
        check("abort_release_count", Count, 4'b0000);
        Ready = 1'b0;
        repeat (3) @(negedge Clock);

        // 16 legal decodes wrap Count to 0, 17th gives 1
        for (int i = 0; i < 16; i++) begin
            int d;
            logic [3:0] c;
            logic [3:0] n;
            d = i % 10;
            c = 4'(d + 3);
            n = 4'((i + 1) % 16);
            decode("wrap", c, 1'b1, 4'(d), SEG[d], 1'b0, n);
        end
        check("wrap_count16", Count, 4'b0000);
        decode("d17", 4'b1100, 1'b1, 4'd9, SEG[9], 1'b0, 4'd1);

        // Illegal codes at the range boundaries
        decode("d0010", 4'b0010, 1'b0, 4'd9, SEG_E, 1'b1, 4'd1);
        decode("d1101", 4'b1101, 1'b0, 4'd9, SEG_E, 1'b1, 4'd1);
        decode("d0000", 4'b0000, 1'b0, 4'd9, SEG_E, 1'b1, 4'd1);
        decode("d0011b", 4'b0011, 1'b1, 4'd0, SEG[0], 1'b0, 4'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
